mio_responder: RTL
==================

MIO_RESPONDER -- requirements
Module: mio_responder

Interface
REQ-001 Parameter RAM_WORDS, default 1024, SHALL set the number of 32-bit RAM words (power of two).
REQ-002 Parameter WAIT_CYCLES, default 1, SHALL set the number of wait states between accept and ready (0..15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous, active-high reset.
REQ-005 mio_req  input  1  SHALL be the bus-master access request (CPU_MIO).
REQ-006 mem_w  input  1  SHALL select write (1) or read (0), qualified by mio_req.
REQ-007 addr  input  32  SHALL be the byte address of the access.
REQ-008 wdata  input  32  SHALL be the write data.
REQ-009 rdata  output  32  SHALL be the read data returned to the master.
REQ-010 MIO_ready  output  1  SHALL be the one-cycle access-complete pulse.
REQ-011 sw  input  16  SHALL be the asynchronous switch inputs.
REQ-012 led  output  16  SHALL be the LED register output.

Function
REQ-013 FSM SHALL have states IDLE, WAIT, ACK.
REQ-014 IDLE with mio_req=1 SHALL latch addr, wdata, mem_w and go to WAIT with wait counter=WAIT_CYCLES, or directly to ACK when WAIT_CYCLES=0.
REQ-015 IDLE with mio_req=0 SHALL remain in IDLE.
REQ-016 WAIT SHALL decrement the counter each cycle and go to ACK in the cycle after it reaches 1.
REQ-017 ACK SHALL assert MIO_ready for exactly one cycle and return to IDLE; a request present in the following IDLE cycle SHALL be accepted (back-to-back allowed).
REQ-018 Latency from the accept cycle to the MIO_ready cycle SHALL be WAIT_CYCLES+1 cycles.
REQ-019 Inputs SHALL be ignored outside IDLE; only latched values are used.
REQ-020 Writes SHALL commit in the ACK cycle, never earlier.
REQ-021 rdata SHALL be valid in the ACK cycle and held until the next ACK; write accesses SHALL leave rdata unchanged.
REQ-022 Address map: addr[31:28]=0x0 -> RAM word addr[log2(RAM_WORDS)+1:2] (upper bits aliased); 0xF000_0000 -> led (R/W, low 16 bits, upper read 0); 0xF000_0004 -> sw (read-only, zero-extended); 0xF000_0008 -> timer (when compiled in).
REQ-023 Unmapped addresses SHALL return rdata=0 on read, ignore writes, and still complete with MIO_ready.
REQ-024 addr[1:0] SHALL be ignored; all accesses are full-word.
REQ-025 sw SHALL pass through a two-flop synchronizer; reads return the synchronized value.

Reset
REQ-026 Reset SHALL force FSM=IDLE, MIO_ready=0, rdata=0, led=0, wait counter=0, synchronizer flops=0, timer=0.
REQ-027 Reset during WAIT or ACK SHALL abort the access with no write committed and no MIO_ready.
REQ-028 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-029 Macro MIO_TIMER_EN defined: 32-bit free-running timer at 0xF000_0008 increments every cycle, wraps 0xFFFF_FFFF->0, read returns value at ACK cycle, write loads wdata in the ACK cycle (increment resumes next cycle).
REQ-030 MIO_TIMER_EN undefined: no timer logic; 0xF000_0008 behaves as unmapped.

Structure
REQ-031 Package mio_pkg SHALL hold the FSM state enum and address constants (LED_ADDR, SW_ADDR, TIMER_ADDR, RAM region nibble).
REQ-032 RAM SHALL be a sub-module mio_ram: single-port, synchronous write, word-addressed, parameterized by RAM_WORDS.

Verification
REQ-033 WAIT_CYCLES=1: write 0x1234_5678 to 0x0000_0010, read 0x0000_0010 -> MIO_ready 2 cycles after each accept, rdata=0x1234_5678.
REQ-034 Write 0x0000_A5A5 to 0xF000_0000 -> led=0xA5A5 from cycle after ACK; read back -> rdata=0x0000_A5A5.
REQ-035 sw=0x00FF, wait 2 cycles, read 0xF000_0004 -> rdata=0x0000_00FF; read 0xF000_0100 -> rdata=0, MIO_ready pulses.
REQ-036 Write 0xDEAD_BEEF to 0x0000_0020 and assert reset during WAIT -> no MIO_ready; read 0x0000_0020 returns prior contents; led=0, rdata=0.
REQ-037 MIO_TIMER_EN: write 0xFFFF_FFFE to 0xF000_0008, read with WAIT_CYCLES=0 accepted 2 cycles after write ACK -> rdata=0x0000_0000 (wrap verified); without macro -> rdata=0.
REQ-038 mio_req held high continuously for 3 reads, WAIT_CYCLES=0 -> MIO_ready pulses every 2 cycles, never two consecutive cycles.

Source files
------------

// File: rtl/mio_pkg.sv
// Shared types and constants for the memory-mapped I/O responder.
// The optional timer peripheral is enabled with the MIO_TIMER_EN macro.
package mio_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } mio_state_e;

   typedef enum logic [2:0] {
      SEL_NONE  = 3'd0,
      SEL_RAM   = 3'd1,
      SEL_LED   = 3'd2,
      SEL_SW    = 3'd3,
      SEL_TIMER = 3'd4
   } mio_sel_e;

   localparam logic [31:0] LED_ADDR   = 32'hF000_0000;
   localparam logic [31:0] SW_ADDR    = 32'hF000_0004;
   localparam logic [31:0] TIMER_ADDR = 32'hF000_0008;
   localparam logic [3:0]  RAM_NIBBLE = 4'h0;

   // Decode a word address (byte address bits [31:2]) into a target.
   // The timer is always decoded here; the top treats it as unmapped
   // when the timer is not compiled in.
   function automatic mio_sel_e decodeAddr(input logic [29:0] wordAddr);
      mio_sel_e sel;
      if (wordAddr[29:26] == RAM_NIBBLE) begin
         sel = SEL_RAM;
      end else if (wordAddr == LED_ADDR[31:2]) begin
         sel = SEL_LED;
      end else if (wordAddr == SW_ADDR[31:2]) begin
         sel = SEL_SW;
      end else if (wordAddr == TIMER_ADDR[31:2]) begin
         sel = SEL_TIMER;
      end else begin
         sel = SEL_NONE;
      end
      return sel;
   endfunction

endpackage

// File: rtl/mio_if.sv
// Bus bundle between a CPU-style master and the MIO responder.
interface mio_if;

   logic        mio_req;
   logic        mem_w;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        MIO_ready;

   modport master (
      output mio_req, mem_w, addr, wdata,
      input  rdata, MIO_ready
   );

   modport slave (
      input  mio_req, mem_w, addr, wdata,
      output rdata, MIO_ready
   );

endinterface

// File: rtl/mio_ram.sv
// Single-port word-addressed RAM: synchronous write, combinational read.
// Contents are deliberately not reset.
module mio_ram #(
   parameter int RAM_WORDS = 1024,
   localparam int AW = $clog2(RAM_WORDS)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wrData_i,
   output logic [31:0]   rdData_o
);

   logic [31:0] mem_q [RAM_WORDS];

   // Write port: one word per cycle when enabled.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wrData_i;
      end
   end

   assign rdData_o = mem_q[addr_i];

endmodule

// File: rtl/mio_responder.sv
// Memory-mapped I/O responder: RAM, LED register, synchronized switches
// and an optional free-running timer (macro MIO_TIMER_EN) behind a
// request / ready handshake with a programmable number of wait states.
module mio_responder
   import mio_pkg::*;
#(
   parameter int RAM_WORDS   = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   mio_if.slave        bus,
   input  logic [15:0] sw,
   output logic [15:0] led
);

   localparam int AW = $clog2(RAM_WORDS);

   mio_state_e  state_q;
   logic [3:0]  waitCnt_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        memW_q;
   logic        ready_q;
   logic [31:0] rdata_q;
   logic [31:0] rdata_d;
   logic [15:0] led_q;
   logic [15:0] swMeta_q;
   logic [15:0] swSync_q;

   logic [31:0] accessAddr;
   logic        accessWrite;
   mio_sel_e    sel;
   logic        commit;
   logic        ramWe;
   logic [31:0] ramRdata;
   logic        unusedByteLane;

`ifdef MIO_TIMER_EN
   logic [31:0] timer_q;
   logic [31:0] timer_d;
`endif

   // In IDLE the live bus is decoded so a zero-wait access can load rdata
   // on its accept edge; afterwards only the latched copy is used.
   assign accessAddr     = (state_q == IDLE) ? bus.addr  : addr_q;
   assign accessWrite    = (state_q == IDLE) ? bus.mem_w : memW_q;
   assign sel            = decodeAddr(accessAddr[31:2]);
   assign unusedByteLane = ^accessAddr[1:0];

   // Writes take effect only at the end of the ACK cycle, and never when
   // reset aborts the access.
   assign commit = (state_q == ACK) && memW_q && !reset;
   assign ramWe  = commit && (sel == SEL_RAM);

   mio_ram #(
      .RAM_WORDS (RAM_WORDS)
   ) u_ram (
      .clk      (clk),
      .we_i     (ramWe),
      .addr_i   (accessAddr[AW+1:2]),
      .wrData_i (wdata_q),
      .rdData_o (ramRdata)
   );

`ifdef MIO_TIMER_EN
   assign timer_d = timer_q + 32'd1;
`endif

   // Read mux: the value the master sees during the ACK cycle.
   always_comb begin
      rdata_d = 32'h0;
      case (sel)
         SEL_RAM:   rdata_d = ramRdata;
         SEL_LED:   rdata_d = {16'h0, led_q};
         SEL_SW:    rdata_d = {16'h0, swSync_q};
`ifdef MIO_TIMER_EN
         SEL_TIMER: rdata_d = timer_d;
`else
         SEL_TIMER: rdata_d = 32'h0;
`endif
         default:   rdata_d = 32'h0;
      endcase
   end

   // Handshake FSM: accept in IDLE, count wait states, pulse ready in ACK.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         waitCnt_q <= 4'd0;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         memW_q    <= 1'b0;
         ready_q   <= 1'b0;
         rdata_q   <= 32'h0;
      end else begin
         case (state_q)
            IDLE: begin
               ready_q <= 1'b0;
               if (bus.mio_req) begin
                  addr_q  <= bus.addr;
                  wdata_q <= bus.wdata;
                  memW_q  <= bus.mem_w;
                  if (WAIT_CYCLES == 0) begin
                     state_q <= ACK;
                     ready_q <= 1'b1;
                     if (!accessWrite) begin
                        rdata_q <= rdata_d;
                     end
                  end else begin
                     state_q   <= WAIT;
                     waitCnt_q <= 4'(WAIT_CYCLES);
                  end
               end
            end
            WAIT: begin
               waitCnt_q <= waitCnt_q - 4'd1;
               if (waitCnt_q == 4'd1) begin
                  state_q <= ACK;
                  ready_q <= 1'b1;
                  if (!accessWrite) begin
                     rdata_q <= rdata_d;
                  end
               end
            end
            ACK: begin
               state_q <= IDLE;
               ready_q <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // LED register, written only through a committed access.
   always_ff @(posedge clk) begin
      if (reset) begin
         led_q <= 16'h0;
      end else if (commit && (sel == SEL_LED)) begin
         led_q <= wdata_q[15:0];
      end
   end

   // Two-flop synchronizer for the asynchronous switch inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         swMeta_q <= 16'h0;
         swSync_q <= 16'h0;
      end else begin
         swMeta_q <= sw;
         swSync_q <= swMeta_q;
      end
   end

`ifdef MIO_TIMER_EN
   // Free-running timer; a committed write loads it, counting resumes next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q <= 32'h0;
      end else if (commit && (sel == SEL_TIMER)) begin
         timer_q <= wdata_q;
      end else begin
         timer_q <= timer_d;
      end
   end
`endif

   assign bus.MIO_ready = ready_q & ~reset;
   assign bus.rdata     = rdata_q;
   assign led           = led_q;

endmodule
